mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one memory/cache port (with busy handshake) between the instruction-fetch path and
//  the load/store path of the RISC-V controller. Data accesses have priority. A starvation
//  counter guarantees fetch progress. Also drives the stall that freezes the PC while waiting.
// PARAMETERS
//  NBITS      8  address and data width
//  MAXSTARVE  4  consecutive data grants won over a pending fetch before fetch is forced (>=1)
// PORTS
//  clock    in   1      rising-edge clock
//  reset    in   1      synchronous, active-low reset (0 = reset)
//  i_req    in   1      fetch request; held high until i_ack
//  i_addr   in   NBITS  fetch address
//  i_ack    out  1      one-cycle pulse: fetch done, i_rdata valid
//  i_rdata  out  NBITS  fetched word (registered)
//  d_req    in   1      load/store request; held high until d_ack
//  d_we     in   1      1 = store (MemWrite), 0 = load (MemRead)
//  d_addr   in   NBITS  data address
//  d_wdata  in   NBITS  store data
//  d_ack    out  1      one-cycle pulse: data access done
//  d_rdata  out  NBITS  load data (registered)
//  m_req    out  1      memory request
//  m_we     out  1      memory write enable
//  m_addr   out  NBITS  memory address
//  m_wdata  out  NBITS  memory write data
//  m_busy   in   1      memory not ready; access completes in a cycle with m_req=1, m_busy=0
//  m_rdata  in   NBITS  read data, valid in the completing cycle
//  stall    out  1      high while i_req or d_req is high and its ack is not pulsing this cycle
// BEHAVIOUR
//  - Reset (reset=0 at an edge): state IDLE; all outputs 0; rdata regs 0; starve cnt 0.
//    Reset mid-access drops m_req next cycle. No ack is issued. The memory access is abandoned.
//  - FSM: IDLE -> BUS_D | BUS_I -> RESP -> IDLE.
//  - IDLE: if d_req && !(i_req && cnt==MAXSTARVE), grant data. Else if i_req, grant fetch.
//    On grant, latch addr/we/wdata into regs and enter BUS_x. With no request, stay in IDLE.
//  - Starve cnt: +1 on each data grant made while i_req=1, saturating at MAXSTARVE.
//    Cleared on every fetch grant.
//  - BUS_x: m_req=1; m_addr/m_we/m_wdata come from the latched regs and stay stable.
//    Requester input changes are ignored. m_we=0 for fetch.
//    If m_busy=1, stay in BUS_x.
//    If m_busy=0, capture m_rdata into x_rdata (loads and fetch only), then go to RESP.
//  - RESP: m_req=0; x_ack=1 for exactly this cycle. No arbitration happens in RESP.
//    The acked requester may keep req high to start a new access, evaluated in the next IDLE.
//  - Latency with busy=0: request at cycle t -> m_req at t+1 -> ack at t+2.
//    Minimum back-to-back spacing is 3 cycles. Each busy cycle adds 1 cycle.
//  - Stores leave d_rdata unchanged. Only one access is outstanding at a time.
//  - i_ack and d_ack are never high in the same cycle.
//  - stall is combinational from req/ack. It is 0 when there is no request.
// TESTING
//  1 i_req=1, i_addr=0x10, m_busy=0, m_rdata=0xA5 -> m_req=1, m_addr=0x10, m_we=0 at t+1;
//    i_ack=1, i_rdata=0xA5 at t+2.
//  2 d_req (load 0x20) and i_req (0x04) together -> data served first (d_ack t+2);
//    fetch m_req at t+4, i_ack at t+5.
//  3 fetch with m_busy=1 for 3 cycles -> m_addr held stable, i_ack at t+5;
//    changing i_addr during the wait has no effect.
//  4 MAXSTARVE=4, d_req and i_req held high continuously -> 4 data accesses, then 1 fetch.
//    Counter returns to 0 and the pattern repeats.
//  5 store d_we=1, d_addr=0x30, d_wdata=0x3C -> m_we=1, m_wdata=0x3C; d_ack pulses;
//    d_rdata keeps its prior value.
//  6 reset=0 during BUS_I with m_busy=1 -> next cycle m_req=0, no ack, outputs 0.
//    After release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-port signals of the arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
    parameter int NBITS = 8
);
    logic             i_req;
    logic [NBITS-1:0] i_addr;
    logic             i_ack;
    logic [NBITS-1:0] i_rdata;
    logic             d_req;
    logic             d_we;
    logic [NBITS-1:0] d_addr;
    logic [NBITS-1:0] d_wdata;
    logic             d_ack;
    logic [NBITS-1:0] d_rdata;
    logic             m_req;
    logic             m_we;
    logic [NBITS-1:0] m_addr;
    logic [NBITS-1:0] m_wdata;
    logic             m_busy;
    logic [NBITS-1:0] m_rdata;
    logic             stall;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_busy, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, stall
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_busy, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store; data wins unless fetch is starved.
// Ack two cycles after grant with m_busy=0, +1 per busy cycle; requests wait (stall) meanwhile.
module mem_arbiter #(
    parameter int NBITS     = 8,
    parameter int MAXSTARVE = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int            CW   = $clog2(MAXSTARVE + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAXSTARVE);

    typedef enum logic [1:0] {IDLE, BUS_D, BUS_I, RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [NBITS-1:0] r_addr;
    logic [NBITS-1:0] r_wdata;
    logic [NBITS-1:0] r_i_rdata;
    logic [NBITS-1:0] r_d_rdata;
    logic             r_we;
    logic             r_resp_d;
    logic [CW-1:0]    r_cnt;

    logic             w_starved;
    logic             w_grant_d;
    logic             w_grant_i;
    logic             w_on_bus;
    logic             w_done;
    logic             w_m_req;
    logic             w_m_we;
    logic [NBITS-1:0] w_m_addr;
    logic [NBITS-1:0] w_m_wdata;
    logic             w_i_ack;
    logic             w_d_ack;

    // A pending fetch that has lost MAXSTARVE grants in a row takes the next slot.
    assign w_starved = bus.i_req && (r_cnt == MAXC);
    assign w_grant_d = (r_state == IDLE) && bus.d_req && !w_starved;
    assign w_grant_i = (r_state == IDLE) && !w_grant_d && bus.i_req;
    assign w_on_bus  = (r_state == BUS_D) || (r_state == BUS_I);
    assign w_done    = w_on_bus && !bus.m_busy;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = BUS_D;
                end else if (w_grant_i) begin
                    w_next = BUS_I;
                end
            end
            BUS_D, BUS_I: begin
                if (!bus.m_busy) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_resp_d  <= 1'b0;
            r_cnt     <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_grant_d) begin
                r_addr   <= bus.d_addr;
                r_we     <= bus.d_we;
                r_wdata  <= bus.d_wdata;
                r_resp_d <= 1'b1;
                if (bus.i_req && (r_cnt != MAXC)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_grant_i) begin
                r_addr   <= bus.i_addr;
                r_we     <= 1'b0;
                r_wdata  <= '0;
                r_resp_d <= 1'b0;
                r_cnt    <= '0;
            end
            if (w_done && (r_state == BUS_I)) begin
                r_i_rdata <= bus.m_rdata;
            end
            // Stores must leave the load-data register untouched.
            if (w_done && (r_state == BUS_D) && !r_we) begin
                r_d_rdata <= bus.m_rdata;
            end
        end
    end

    always_comb begin
        w_m_req   = 1'b0;
        w_m_we    = 1'b0;
        w_m_addr  = '0;
        w_m_wdata = '0;
        w_i_ack   = 1'b0;
        w_d_ack   = 1'b0;
        case (r_state)
            BUS_D, BUS_I: begin
                w_m_req   = 1'b1;
                w_m_we    = r_we;
                w_m_addr  = r_addr;
                w_m_wdata = r_wdata;
            end
            RESP: begin
                w_i_ack = !r_resp_d;
                w_d_ack = r_resp_d;
            end
            default: begin
                w_m_req = 1'b0;
            end
        endcase
    end

    assign bus.m_req   = w_m_req;
    assign bus.m_we    = w_m_we;
    assign bus.m_addr  = w_m_addr;
    assign bus.m_wdata = w_m_wdata;
    assign bus.i_ack   = w_i_ack;
    assign bus.d_ack   = w_d_ack;
    assign bus.i_rdata = r_i_rdata;
    assign bus.d_rdata = r_d_rdata;
    assign bus.stall   = (bus.i_req && !w_i_ack) || (bus.d_req && !w_d_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level model of the arbiter checked every cycle, plus directed literal scenarios.
module tb_mem_arbiter;
    localparam int NB = 8;
    localparam int MS = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter_if #(.NBITS(NB)) bus();

    mem_arbiter #(.NBITS(NB), .MAXSTARVE(MS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: who owns the port (0 none, 1 data, 2 fetch), whether its access finished.
    int       own;
    bit       done;
    int       starve;
    logic [7:0] l_addr, l_wdata, e_irdata, e_drdata;
    bit       l_we;
    logic     e_mreq, e_iack, e_dack, e_stall;

    logic       o_mreq, o_we, o_iack, o_dack, o_stall;
    logic [7:0] o_addr, o_wdata, o_irdata, o_drdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        own      = 0;
        done     = 0;
        starve   = 0;
        e_irdata = 8'h00;
        e_drdata = 8'h00;
        l_addr   = 8'h00;
        l_wdata  = 8'h00;
        l_we     = 0;
    endtask

    task automatic idle_in();
        bus.i_req   = 1'b0;
        bus.i_addr  = 8'h00;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h00;
        bus.d_wdata = 8'h00;
        bus.m_busy  = 1'b0;
        bus.m_rdata = 8'h00;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        @(negedge clock);
        e_mreq  = (own != 0) && !done;
        e_iack  = done && (own == 2);
        e_dack  = done && (own == 1);
        e_stall = (bus.i_req && !e_iack) || (bus.d_req && !e_dack);
        o_mreq   = bus.m_req;
        o_we     = bus.m_we;
        o_addr   = bus.m_addr;
        o_wdata  = bus.m_wdata;
        o_iack   = bus.i_ack;
        o_dack   = bus.d_ack;
        o_stall  = bus.stall;
        o_irdata = bus.i_rdata;
        o_drdata = bus.d_rdata;
        chk("m_req",   32'(o_mreq),   32'(e_mreq));
        chk("m_addr",  32'(o_addr),   32'(e_mreq ? l_addr : 8'h00));
        chk("m_we",    32'(o_we),     32'(e_mreq ? l_we : 1'b0));
        if (e_mreq && l_we) chk("m_wdata", 32'(o_wdata), 32'(l_wdata));
        chk("i_ack",   32'(o_iack),   32'(e_iack));
        chk("d_ack",   32'(o_dack),   32'(e_dack));
        chk("stall",   32'(o_stall),  32'(e_stall));
        chk("i_rdata", 32'(o_irdata), 32'(e_irdata));
        chk("d_rdata", 32'(o_drdata), 32'(e_drdata));
        @(posedge clock);
        if (!reset) begin
            mreset();
        end else if (own == 0) begin
            if (bus.d_req && !(bus.i_req && starve == MS)) begin
                own = 1; l_addr = bus.d_addr; l_we = bus.d_we; l_wdata = bus.d_wdata;
                if (bus.i_req && starve < MS) starve++;
            end else if (bus.i_req) begin
                own = 2; l_addr = bus.i_addr; l_we = 0; starve = 0;
            end
        end else if (!done) begin
            if (!bus.m_busy) begin
                if (own == 2) e_irdata = bus.m_rdata;
                else if (!l_we) e_drdata = bus.m_rdata;
                done = 1;
            end
        end else begin
            own  = 0;
            done = 0;
        end
        #1;
    endtask

    int         seq[$];
    logic [7:0] prior;

    initial begin
        idle_in();
        mreset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cyc();
        chk("rst_m_req", 32'(o_mreq), 32'h0);
        chk("rst_i_rdata", 32'(o_irdata), 32'h0);
        reset = 1'b1;
        cyc();

        // Plain fetch, no busy.
        bus.i_req = 1'b1; bus.i_addr = 8'h10;
        cyc();
        chk("t1_stall", 32'(o_stall), 32'h1);
        bus.m_rdata = 8'hA5;
        cyc();
        chk("t1_mreq", 32'(o_mreq), 32'h1);
        chk("t1_maddr", 32'(o_addr), 32'h10);
        chk("t1_mwe", 32'(o_we), 32'h0);
        cyc();
        chk("t1_iack", 32'(o_iack), 32'h1);
        chk("t1_irdata", 32'(o_irdata), 32'hA5);
        chk("t1_stall_ack", 32'(o_stall), 32'h0);
        bus.i_req = 1'b0;
        cyc();

        // Simultaneous load and fetch: data first.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h20;
        bus.i_req = 1'b1; bus.i_addr = 8'h04; bus.m_rdata = 8'h5A;
        cyc();
        cyc();
        chk("t2_maddr_d", 32'(o_addr), 32'h20);
        cyc();
        chk("t2_dack", 32'(o_dack), 32'h1);
        chk("t2_drdata", 32'(o_drdata), 32'h5A);
        bus.d_req = 1'b0; bus.m_rdata = 8'hC3;
        cyc();
        chk("t2_gap", 32'(o_mreq), 32'h0);
        cyc();
        chk("t2_mreq_i", 32'(o_mreq), 32'h1);
        chk("t2_maddr_i", 32'(o_addr), 32'h04);
        cyc();
        chk("t2_iack", 32'(o_iack), 32'h1);
        chk("t2_irdata", 32'(o_irdata), 32'hC3);
        bus.i_req = 1'b0;
        cyc();

        // Fetch with three busy cycles and a wandering i_addr.
        bus.i_req = 1'b1; bus.i_addr = 8'h40;
        cyc();
        for (int k = 0; k < 3; k++) begin
            bus.m_busy = 1'b1; bus.i_addr = 8'(8'h41 + k);
            cyc();
            chk("t3_hold", 32'(o_addr), 32'h40);
        end
        bus.m_busy = 1'b0; bus.m_rdata = 8'h99;
        cyc();
        chk("t3_last_bus", 32'(o_addr), 32'h40);
        chk("t3_no_ack", 32'(o_iack), 32'h0);
        cyc();
        chk("t3_iack", 32'(o_iack), 32'h1);
        chk("t3_irdata", 32'(o_irdata), 32'h99);
        bus.i_req = 1'b0;
        cyc();

        // Both requests held: four data accesses then one fetch, repeating.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.i_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.d_addr = 8'($urandom); bus.i_addr = 8'($urandom); bus.m_rdata = 8'($urandom);
            cyc();
            if (o_dack) seq.push_back(1);
            if (o_iack) seq.push_back(2);
        end
        bus.d_req = 1'b0; bus.i_req = 1'b0;
        chk("t4_count", 32'(seq.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk("t4_order", (i < seq.size()) ? 32'(seq[i]) : 32'h0, (i % 5 == 4) ? 32'd2 : 32'd1);
        end
        cyc();

        // Store: write path driven, load data untouched.
        prior = e_drdata;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h30; bus.d_wdata = 8'h3C;
        bus.m_rdata = 8'hEE;
        cyc();
        cyc();
        chk("t5_mwe", 32'(o_we), 32'h1);
        chk("t5_mwdata", 32'(o_wdata), 32'h3C);
        chk("t5_maddr", 32'(o_addr), 32'h30);
        cyc();
        chk("t5_dack", 32'(o_dack), 32'h1);
        chk("t5_drdata_kept", 32'(o_drdata), 32'(prior));
        bus.d_req = 1'b0;
        cyc();

        // Reset while a fetch waits on a busy memory.
        bus.i_req = 1'b1; bus.i_addr = 8'h50;
        cyc();
        bus.m_busy = 1'b1;
        cyc();
        chk("t6_mreq_pre", 32'(o_mreq), 32'h1);
        reset = 1'b0; bus.i_req = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("t6_mreq", 32'(o_mreq), 32'h0);
        chk("t6_iack", 32'(o_iack), 32'h0);
        chk("t6_irdata", 32'(o_irdata), 32'h0);
        chk("t6_drdata", 32'(o_drdata), 32'h0);
        bus.m_busy = 1'b0; bus.i_req = 1'b1; bus.i_addr = 8'h60; bus.m_rdata = 8'h3E;
        cyc();
        cyc();
        cyc();
        chk("t6_iack_after", 32'(o_iack), 32'h1);
        chk("t6_irdata_after", 32'(o_irdata), 32'h3E);
        bus.i_req = 1'b0;
        cyc();

        // Randomized traffic, busy stretches and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (bus.i_req) begin
                if (e_iack) bus.i_req = ($urandom_range(0, 1) == 1);
            end else begin
                bus.i_req = ($urandom_range(0, 3) == 0);
            end
            if (bus.d_req) begin
                if (e_dack) bus.d_req = ($urandom_range(0, 1) == 1);
            end else begin
                bus.d_req = ($urandom_range(0, 2) == 0);
            end
            bus.i_addr  = 8'($urandom);
            bus.d_addr  = 8'($urandom);
            bus.d_wdata = 8'($urandom);
            bus.d_we    = ($urandom_range(0, 1) == 1);
            bus.m_busy  = ($urandom_range(0, 3) == 0);
            bus.m_rdata = 8'($urandom);
            reset       = ($urandom_range(0, 199) != 0);
            cyc();
        end
        reset = 1'b1;
        idle_in();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
